led_frame_sched: RTL and testbench

- Frame-level controller for the LED strip datapath.
- Arbitrates between two frame sources (source 0: ambient capture; source 1: override/static pattern) and copies the winner's LEDNUM GRB words into the strip frame buffer.
- Fires the serializer start pulse, waits for serializer done, then enforces the WS2812 latch/reset gap before the next frame.
- Sits between the capture logic and the collect/led serializer pair. All logic runs in the clk domain.

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_frame_sched_if.sv | 37 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/led_frame_sched.sv | 127 ++++++++++++
 tb/tb_led_frame_sched.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED frame scheduler slice.
// Holds the GRB word type, the scheduler state encoding and default sizes.
// Also provides a small counter-width helper used by the top.
package led_pkg;

   typedef logic [23:0] grb_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ACK,
      START,
      WAIT_DONE,
      GAP
   } sched_state_t;

   localparam int LEDNUM_DEF         = 32;
   localparam int LATCH_CYCLES_DEF   = 4000;
   localparam int ADDR_W_DEF         = 6;
   localparam int TIMEOUT_CYCLES_DEF = 65535;

   // Bits needed to count 0..limit-1, never less than one bit
   function automatic int cnt_w(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// Bundle of the scheduler's source, frame-buffer, serializer and status signals.
// master = scheduler side, slave = surrounding capture/buffer/serializer side.
// Pure wiring, no logic.
interface led_frame_sched_if
   import led_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic [1:0]        src_req;
   logic [1:0]        src_ack;
   logic [ADDR_W-1:0] src_addr;
   grb_t              src_rdata0;
   grb_t              src_rdata1;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   grb_t              buf_wdata;
   logic              led_start;
   logic              led_done;
   logic [1:0]        grant;
   logic              busy;
   logic [15:0]       frame_cnt;
   logic              timeout_err;

   modport master (
      input  src_req, src_rdata0, src_rdata1, led_done,
      output src_ack, src_addr, buf_we, buf_addr, buf_wdata,
             led_start, grant, busy, frame_cnt, timeout_err
   );

   modport slave (
      output src_req, src_rdata0, src_rdata1, led_done,
      input  src_ack, src_addr, buf_we, buf_addr, buf_wdata,
             led_start, grant, busy, frame_cnt, timeout_err
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the source that did not win last.
// Grant is combinational from req; the last-winner pointer updates on upd.
// Reset points the pointer at source 1 so source 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   logic last;

   // Lone requester wins; on a tie the source other than the last winner wins
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Record the winner whenever a grant is committed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= 1'b1;
      else if (upd && (gnt != 2'b00))
         last <= gnt[1];
   end

endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler: arbitrates two sources, copies LEDNUM words to the strip buffer,
// starts the serializer, waits for done (with timeout) and holds the latch gap.
// Request to led_start is LEDNUM+3 cycles; requests are levels so none are lost while busy.
module led_frame_sched
   import led_pkg::*;
#(
   parameter int LEDNUM         = LEDNUM_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int LATCH_CYCLES   = LATCH_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic ready,
   led_frame_sched_if.master bus
);

   localparam int LW = cnt_w(LEDNUM + 1);
   localparam int GW = cnt_w(LATCH_CYCLES);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);

   sched_state_t state, state_nx;
   logic [1:0]   arb_gnt;
   logic         arb_upd;
   logic [1:0]   grant_q;
   logic [LW-1:0] ld_cnt;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]  frame_cnt_q;
   logic         err_q;
   logic         ld_last;
   logic         gap_last;
   logic         tmo_last;

   assign ld_last  = (ld_cnt  == LW'(LEDNUM));
   assign gap_last = (gap_cnt == GW'(LATCH_CYCLES - 1));
   assign tmo_last = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (ready),
      .req   (bus.src_req),
      .upd   (arb_upd),
      .gnt   (arb_gnt)
   );

   // State register
   always_ff @(posedge clk or negedge ready) begin
      if (!ready)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; the arbiter pointer only moves when a frame is actually taken
   always_comb begin
      state_nx = state;
      arb_upd  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.src_req != 2'b00) begin
               state_nx = LOAD;
               arb_upd  = 1'b1;
            end
         end
         LOAD:      if (ld_last) state_nx = ACK;
         ACK:       state_nx = START;
         START:     state_nx = WAIT_DONE;
         WAIT_DONE: if (bus.led_done || tmo_last) state_nx = GAP;
         GAP:       if (gap_last) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Copy, timeout and gap counters plus owner, frame count and sticky error
   always_ff @(posedge clk or negedge ready) begin
      if (!ready) begin
         grant_q     <= 2'b00;
         ld_cnt      <= '0;
         gap_cnt     <= '0;
         tmo_cnt     <= '0;
         frame_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         ld_cnt  <= (state == LOAD && !ld_last) ? ld_cnt + LW'(1) : '0;
         gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + GW'(1) : '0;
         if (state == START)
            tmo_cnt <= '0;
         else if (state == WAIT_DONE && !tmo_last)
            tmo_cnt <= tmo_cnt + TW'(1);
         if (state == IDLE && arb_gnt != 2'b00)
            grant_q <= arb_gnt;
         else if (state == GAP && gap_last)
            grant_q <= 2'b00;
         // A done arriving on the expiry cycle counts as a good frame
         if (state == WAIT_DONE) begin
            if (bus.led_done)
               frame_cnt_q <= frame_cnt_q + 16'd1;
            else if (tmo_last)
               err_q <= 1'b1;
         end
      end
   end

   // Outputs; the buffer write trails the source read by one cycle to match read latency
   always_comb begin
      bus.src_addr    = '0;
      bus.buf_we      = 1'b0;
      bus.buf_addr    = '0;
      bus.buf_wdata   = '0;
      if (state == LOAD) begin
         if (ld_cnt < LW'(LEDNUM))
            bus.src_addr = ADDR_W'(ld_cnt);
         if (ld_cnt != '0) begin
            bus.buf_we    = 1'b1;
            bus.buf_addr  = ADDR_W'(ld_cnt - LW'(1));
            bus.buf_wdata = grant_q[1] ? bus.src_rdata1 : bus.src_rdata0;
         end
      end
      bus.src_ack     = (state == ACK) ? grant_q : 2'b00;
      bus.led_start   = (state == START);
      bus.busy        = (state != IDLE);
      bus.grant       = grant_q;
      bus.frame_cnt   = frame_cnt_q;
      bus.timeout_err = err_q;
   end

endmodule

// File: tb/tb_led_frame_sched.sv
// Self-checking bench for led_frame_sched with randomized source data and done timing.
// Expected owners, copy contents, frame counts and error flag come from a reference model.
// Each scenario task drives its own stimulus and compares inline.
module tb_led_frame_sched;

   localparam int LEDNUM = 32;
   localparam int ADDR_W = 6;
   localparam int LATCH  = 200;
   localparam int TMO    = 100;

   logic clk   = 1'b0;
   logic ready = 1'b0;

   led_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

   led_frame_sched #(
      .LEDNUM(LEDNUM), .ADDR_W(ADDR_W), .LATCH_CYCLES(LATCH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk   (clk),
      .ready (ready),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Source memories with one-cycle registered read
   logic [23:0] mem0 [64];
   logic [23:0] mem1 [64];
   always @(posedge clk) begin
      bus.src_rdata0 <= mem0[bus.src_addr];
      bus.src_rdata1 <= mem1[bus.src_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit rr_last    = 1'b1;
   int exp_frames = 0;

   // Observations of one frame
   logic [1:0]        ob_grant;
   logic [1:0]        ob_ack;
   int                ob_ack_n;
   int                ob_lat;
   int                ob_start_cyc;
   int                ob_done_cyc;
   int                ob_err_rel;
   bit                ob_gchg;
   bit                ob_hang;
   logic [ADDR_W-1:0] wr_addr [$];
   logic [23:0]       wr_data [$];

   task automatic model_pick(input logic [1:0] r, output logic [1:0] g);
      if (r == 2'b11) g = rr_last ? 2'b01 : 2'b10;
      else            g = r;
      if (g != 2'b00) rr_last = g[1];
   endtask

   // Number of captured writes that differ from the granted source's contents at that index
   function automatic int bad_writes(input bit src);
      int bad = 0;
      for (int i = 0; i < wr_addr.size(); i++) begin
         logic [23:0] e;
         e = src ? mem1[i] : mem0[i];
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== e) bad++;
      end
      return bad;
   endfunction

   task automatic fill_mem(input bit ramp0);
      for (int i = 0; i < 64; i++) begin
         mem0[i] = ramp0 ? 24'(i * 3) : 24'($urandom);
         mem1[i] = 24'($urandom);
      end
   endtask

   // Runs one frame from an IDLE cycle: requests, collects writes/ack/start, drives done, waits for idle
   task automatic do_frame(input logic [1:0] req, input bit hold, input int done_dly, input int drop_addr);
      bit err_before;
      bit idle;
      ob_grant = 2'b00; ob_ack = 2'b00; ob_ack_n = 0; ob_lat = -1;
      ob_start_cyc = -1; ob_done_cyc = -1; ob_err_rel = -1; ob_gchg = 1'b0; ob_hang = 1'b0;
      wr_addr.delete(); wr_data.delete();
      err_before = bus.timeout_err;
      bus.src_req = req;
      for (int n = 1; n <= 100 && ob_lat < 0; n++) begin
         @(posedge clk); #1;
         if (ob_grant == 2'b00) ob_grant = bus.grant;
         else if (bus.grant !== ob_grant) ob_gchg = 1'b1;
         if (bus.buf_we) begin
            wr_addr.push_back(bus.buf_addr);
            wr_data.push_back(bus.buf_wdata);
         end
         if (bus.src_ack != 2'b00) begin
            ob_ack = ob_ack | bus.src_ack;
            ob_ack_n++;
            if (!hold) bus.src_req = 2'b00;
         end
         if (drop_addr >= 0 && bus.grant != 2'b00 && bus.src_addr == ADDR_W'(drop_addr))
            bus.src_req = 2'b00;
         if (bus.led_start) begin
            ob_lat = n;
            ob_start_cyc = cyc;
         end
      end
      if (ob_lat < 0) begin
         ob_hang = 1'b1;
         return;
      end
      idle = 1'b0;
      for (int k = 1; k <= LATCH + TMO + 50; k++) begin
         @(posedge clk); #1;
         bus.led_done = (k == done_dly);
         if (k == done_dly) ob_done_cyc = cyc;
         if (bus.busy && bus.grant !== ob_grant) ob_gchg = 1'b1;
         if (bus.src_ack != 2'b00) ob_ack_n++;
         if (!err_before && bus.timeout_err && ob_err_rel < 0) ob_err_rel = k;
         if (!bus.busy) begin
            idle = 1'b1;
            break;
         end
      end
      bus.led_done = 1'b0;
      if (!idle) ob_hang = 1'b1;
   endtask

   task automatic test_reset();
      logic [59:0] v;
      bus.src_req = 2'b00; bus.led_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      v = {bus.src_ack, bus.src_addr, bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.led_start,
           bus.grant, bus.busy, bus.frame_cnt, bus.timeout_err};
      n_checks++;
      if (v !== 60'd0) $display("FAIL reset_outputs got=%h exp=0", v); else n_pass++;
      @(negedge clk) ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL idle_no_req busy got=%b exp=0", bus.busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] g;
      int prev_done = -1;
      fill_mem(1'b0);
      for (int f = 0; f < 4; f++) begin
         model_pick(2'b11, g);
         do_frame(2'b11, 1'b1, int'($urandom_range(1, 60)), -1);
         exp_frames++;
         n_checks++;
         if (ob_hang) $display("FAIL b2b_complete frame %0d got=hang exp=done", f); else n_pass++;
         n_checks++;
         if (ob_grant !== g) $display("FAIL b2b_grant frame %0d got=%b exp=%b", f, ob_grant, g); else n_pass++;
         n_checks++;
         if (ob_ack !== g || ob_ack_n != 1)
            $display("FAIL b2b_ack frame %0d got=%b x%0d exp=%b x1", f, ob_ack, ob_ack_n, g);
         else n_pass++;
         n_checks++;
         if (wr_addr.size() != LEDNUM || bad_writes(g[1]) != 0)
            $display("FAIL b2b_writes frame %0d got=%0d writes %0d bad exp=%0d writes 0 bad",
                     f, wr_addr.size(), bad_writes(g[1]), LEDNUM);
         else n_pass++;
         n_checks++;
         if (bus.frame_cnt !== 16'(exp_frames))
            $display("FAIL b2b_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames);
         else n_pass++;
         if (prev_done >= 0) begin
            n_checks++;
            if (ob_start_cyc - prev_done < LEDNUM + LATCH + 3)
               $display("FAIL b2b_latch_gap got=%0d exp>=%0d", ob_start_cyc - prev_done, LEDNUM + LATCH + 3);
            else n_pass++;
         end
         prev_done = ob_done_cyc;
      end
      bus.src_req = 2'b00;
   endtask

   task automatic test_single();
      logic [1:0] g;
      fill_mem(1'b1);
      model_pick(2'b01, g);
      do_frame(2'b01, 1'b0, int'($urandom_range(1, 60)), -1);
      exp_frames++;
      n_checks++;
      if (ob_lat != LEDNUM + 3) $display("FAIL single_latency got=%0d exp=%0d", ob_lat, LEDNUM + 3); else n_pass++;
      n_checks++;
      if (ob_grant !== g || ob_gchg) $display("FAIL single_grant got=%b chg=%b exp=%b", ob_grant, ob_gchg, g); else n_pass++;
      n_checks++;
      if (ob_ack !== 2'b01 || ob_ack_n != 1) $display("FAIL single_ack got=%b x%0d exp=01 x1", ob_ack, ob_ack_n); else n_pass++;
      n_checks++;
      if (wr_addr.size() != LEDNUM || bad_writes(1'b0) != 0)
         $display("FAIL single_writes got=%0d writes %0d bad exp=%0d writes 0 bad", wr_addr.size(), bad_writes(1'b0), LEDNUM);
      else n_pass++;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames) || ob_hang)
         $display("FAIL single_frame_cnt got=%0d hang=%b exp=%0d", bus.frame_cnt, ob_hang, exp_frames);
      else n_pass++;
   endtask

   task automatic test_done_at_timeout();
      logic [1:0] g;
      fill_mem(1'b0);
      model_pick(2'b01, g);
      do_frame(2'b01, 1'b0, TMO, -1);
      exp_frames++;
      n_checks++;
      if (bus.timeout_err !== 1'b0) $display("FAIL done_at_expiry_err got=%b exp=0", bus.timeout_err); else n_pass++;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames) || ob_hang)
         $display("FAIL done_at_expiry_cnt got=%0d hang=%b exp=%0d", bus.frame_cnt, ob_hang, exp_frames);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [1:0] g;
      fill_mem(1'b0);
      model_pick(2'b10, g);
      do_frame(2'b10, 1'b0, -1, -1);
      n_checks++;
      if (ob_err_rel != TMO + 1 || ob_hang)
         $display("FAIL timeout_rise got=%0d hang=%b exp=%0d", ob_err_rel, ob_hang, TMO + 1);
      else n_pass++;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames) || bus.busy !== 1'b0)
         $display("FAIL timeout_cnt got=%0d busy=%b exp=%0d busy=0", bus.frame_cnt, bus.busy, exp_frames);
      else n_pass++;
      n_checks++;
      if (ob_ack !== g) $display("FAIL timeout_ack got=%b exp=%b", ob_ack, g); else n_pass++;
      model_pick(2'b01, g);
      do_frame(2'b01, 1'b0, int'($urandom_range(1, 60)), -1);
      exp_frames++;
      n_checks++;
      if (bus.timeout_err !== 1'b1 || bus.frame_cnt !== 16'(exp_frames))
         $display("FAIL timeout_sticky got=err %b cnt %0d exp=err 1 cnt %0d", bus.timeout_err, bus.frame_cnt, exp_frames);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      logic [59:0] v;
      logic [1:0]  g;
      bit hit = 1'b0;
      v = '1;
      fill_mem(1'b0);
      bus.src_req = 2'b11;
      for (int n = 0; n < 80 && !hit; n++) begin
         @(posedge clk); #1;
         if (bus.buf_we && bus.buf_addr == ADDR_W'(10)) begin
            hit = 1'b1;
            #2 ready = 1'b0;
            #1 v = {bus.src_ack, bus.src_addr, bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.led_start,
                    bus.grant, bus.busy, bus.frame_cnt, bus.timeout_err};
         end
      end
      n_checks++;
      if (!hit || v !== 60'd0) $display("FAIL reset_mid_load got=hit %b outs %h exp=hit 1 outs 0", hit, v); else n_pass++;
      rr_last = 1'b1;
      exp_frames = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) ready = 1'b1;
      model_pick(2'b11, g);
      do_frame(2'b11, 1'b0, int'($urandom_range(1, 60)), -1);
      exp_frames++;
      n_checks++;
      if (ob_grant !== g) $display("FAIL post_reset_grant got=%b exp=%b", ob_grant, g); else n_pass++;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames) || bus.timeout_err !== 1'b0)
         $display("FAIL post_reset_state got=cnt %0d err %b exp=cnt %0d err 0", bus.frame_cnt, bus.timeout_err, exp_frames);
      else n_pass++;
   endtask

   task automatic test_drop_mid_load();
      logic [1:0] g;
      fill_mem(1'b0);
      model_pick(2'b10, g);
      do_frame(2'b10, 1'b0, int'($urandom_range(1, 60)), 5);
      exp_frames++;
      n_checks++;
      if (wr_addr.size() != LEDNUM || bad_writes(1'b1) != 0)
         $display("FAIL drop_writes got=%0d writes %0d bad exp=%0d writes 0 bad", wr_addr.size(), bad_writes(1'b1), LEDNUM);
      else n_pass++;
      n_checks++;
      if (ob_ack !== g || ob_ack_n != 1 || ob_lat != LEDNUM + 3)
         $display("FAIL drop_ack_start got=ack %b x%0d lat %0d exp=ack %b x1 lat %0d", ob_ack, ob_ack_n, ob_lat, g, LEDNUM + 3);
      else n_pass++;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames)) $display("FAIL drop_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); else n_pass++;
      @(posedge clk); #1;
      bus.led_done = 1'b1;
      @(posedge clk); #1;
      bus.led_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.frame_cnt !== 16'(exp_frames) || bus.busy !== 1'b0)
         $display("FAIL stray_done got=cnt %0d busy %b exp=cnt %0d busy 0", bus.frame_cnt, bus.busy, exp_frames);
      else n_pass++;
   endtask

   initial begin
      bus.src_req  = 2'b00;
      bus.led_done = 1'b0;
      test_reset();
      test_back_to_back();
      test_single();
      test_done_at_timeout();
      test_timeout();
      test_reset_mid_load();
      test_drop_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
